serial_subtractor: RTL

Bit-serial N-bit subtractor with borrow-in and borrow-out. It computes {bout,diff} = a - b - bin one bit per clock, LSB first, using a single borrow flip-flop. It is the inverse-operation companion to the team's combinational N-bit adder, for area-constrained datapaths. Operands enter through a start/ready handshake and the result is flagged by a one-cycle done pulse.

---
 rtl/serial_subtractor.sv | 100 ++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: {bout,diff} = a - b - bin, one bit per clock, LSB first.
// Operands enter on start && ready; done pulses for one cycle when the result is valid.
module serial_subtractor #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             ready,
    output logic             busy,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_ash;
    logic [WIDTH-1:0]  r_bsh;
    logic [WIDTH-1:0]  r_diff;
    logic [CntW-1:0]   r_cnt;
    logic              r_brw;
    logic              r_bout;

    logic              w_accept;
    logic              w_last;
    logic              w_d;
    logic              w_brw_next;

    assign w_accept   = (r_state == StIdle) && start;
    assign w_last     = (r_state == StRun) && (r_cnt == CntLast);
    assign w_d        = r_ash[0] ^ r_bsh[0] ^ r_brw;
    assign w_brw_next = (~r_ash[0] & r_bsh[0]) | (~(r_ash[0] ^ r_bsh[0]) & r_brw);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (start) w_state_next = StRun;
            StRun:   if (r_cnt == CntLast) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ash  <= '0;
            r_bsh  <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
            r_bout <= 1'b0;
        end else if (w_accept) begin
            r_ash  <= a;
            r_bsh  <= b;
            r_brw  <= bin;
            r_cnt  <= '0;
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (r_state == StRun) begin
            r_ash  <= r_ash >> 1;
            r_bsh  <= r_bsh >> 1;
            r_brw  <= w_brw_next;
            // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
            r_diff <= {w_d, r_diff[WIDTH-1:1]};
            if (w_last) begin
                r_bout <= w_brw_next;
            end else begin
                r_cnt  <= r_cnt + CntW'(1);
            end
        end
    end

    assign ready = (r_state == StIdle);
    assign busy  = (r_state == StRun) || (r_state == StDone);
    assign done  = (r_state == StDone);
    assign diff  = r_diff;
    assign bout  = r_bout;

endmodule
